// File: rtl/uart_tx_scheduler.sv
// Round-robin byte-send scheduler in front of a UART control/status register port.
// Each accepted byte is sequenced as: load data + active, poll busy rise/fall, clear active.
module uart_tx_scheduler #(
  parameter int NUM_REQ       = 2,
  parameter int ST_BUSY_BIT   = 0,
  parameter int START_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           cfg_baud_sel,
  input  logic [1:0]           cfg_frame_size,
  input  logic [1:0]           cfg_parity,
  input  logic                 cfg_stop_bit,
  input  logic                 cfg_apply,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   tx_done,
  output logic                 tx_err,
  output logic                 ctl_reg_we,
  output logic [18:0]          ctl_reg_wdata,
  output logic [18:0]          ctl_reg_wmask,
  input  logic [18:0]          ctl_reg_rdata,
  output logic                 st_reg_re,
  output logic [11:0]          st_reg_rmask,
  input  logic [11:0]          st_reg_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = $clog2(START_TIMEOUT) + 1;

  localparam logic [18:0] CFG_MASK   = 19'h003FE;
  localparam logic [18:0] LOAD_MASK  = 19'h7FC01;
  localparam logic [18:0] CLEAR_MASK = 19'h00001;
  localparam logic [11:0] BUSY_MASK  = 12'(1) << ST_BUSY_BIT;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(START_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_CFG,
    ST_ARB,
    ST_LOAD,
    ST_WAIT_START,
    ST_WAIT_DONE,
    ST_CLEAR
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [7:0]       data_q, data_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic             pending_cfg, pending_nxt;

  logic             busy;
  logic [8:0]       cfg_bits;
  logic             grant_found;
  logic [IDX_W-1:0] grant_idx;
  logic [7:0]       grant_data;

  // The readback port is reserved; only the busy bit of status is consumed.
  logic unused_rdata;
  assign unused_rdata = ^ctl_reg_rdata ^ ^st_reg_rdata;

  assign busy     = st_reg_rdata[ST_BUSY_BIT];
  assign cfg_bits = {cfg_baud_sel, cfg_stop_bit, cfg_parity, cfg_frame_size};

  // Round robin: lowest valid index above ptr wins, else lowest at or below ptr.
  always_comb begin
    logic             hi_found, lo_found;
    logic [IDX_W-1:0] hi_idx, lo_idx;
    logic [7:0]       hi_data, lo_data;
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    hi_data  = '0;
    lo_data  = '0;
    for (int c = NUM_REQ - 1; c >= 0; c--) begin
      if (req_valid[c]) begin
        if (c > int'(ptr)) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(c);
          hi_data  = req_data[8*c +: 8];
        end else begin
          lo_found = 1'b1;
          lo_idx   = IDX_W'(c);
          lo_data  = req_data[8*c +: 8];
        end
      end
    end
    grant_found = hi_found | lo_found;
    grant_idx   = hi_found ? hi_idx  : lo_idx;
    grant_data  = hi_found ? hi_data : lo_data;
  end

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    idx_nxt       = idx;
    data_nxt      = data_q;
    timer_nxt     = timer;
    pending_nxt   = pending_cfg;
    ctl_reg_we    = 1'b0;
    ctl_reg_wdata = '0;
    ctl_reg_wmask = '0;
    st_reg_re     = 1'b0;
    st_reg_rmask  = '0;
    req_ready     = '0;
    tx_done       = '0;
    tx_err        = 1'b0;

    // Outside ARB a config request is parked; repeated pulses merge into one.
    if (state != ST_ARB && cfg_apply) pending_nxt = 1'b1;

    unique case (state)
      ST_CFG: begin
        ctl_reg_we    = 1'b1;
        ctl_reg_wdata = {8'h00, 1'b0, cfg_bits, 1'b0};
        ctl_reg_wmask = CFG_MASK;
        state_nxt     = ST_ARB;
      end
      ST_ARB: begin
        if (pending_cfg || cfg_apply) begin
          pending_nxt = 1'b0;
          state_nxt   = ST_CFG;
        end else if (grant_found) begin
          req_ready = NUM_REQ'(1) << grant_idx;
          ptr_nxt   = grant_idx;
          idx_nxt   = grant_idx;
          data_nxt  = grant_data;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        ctl_reg_we    = 1'b1;
        ctl_reg_wdata = {data_q, 1'b1, cfg_bits, 1'b1};
        ctl_reg_wmask = LOAD_MASK;
        timer_nxt     = '0;
        state_nxt     = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        st_reg_re    = 1'b1;
        st_reg_rmask = BUSY_MASK;
        if (busy) begin
          state_nxt = ST_WAIT_DONE;
        end else if (timer == TMR_LAST) begin
          tx_err    = 1'b1;
          state_nxt = ST_CLEAR;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        st_reg_re    = 1'b1;
        st_reg_rmask = BUSY_MASK;
        if (!busy) begin
          tx_done   = NUM_REQ'(1) << idx;
          state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        ctl_reg_we    = 1'b1;
        ctl_reg_wdata = {data_q, 1'b1, cfg_bits, 1'b0};
        ctl_reg_wmask = CLEAR_MASK;
        state_nxt     = ST_ARB;
      end
      default: state_nxt = ST_CFG;
    endcase

    // Held in reset, the port stays quiet even though the state already reads CFG.
    if (rst) begin
      ctl_reg_we    = 1'b0;
      ctl_reg_wdata = '0;
      ctl_reg_wmask = '0;
      st_reg_re     = 1'b0;
      st_reg_rmask  = '0;
      req_ready     = '0;
      tx_done       = '0;
      tx_err        = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_CFG;
      ptr         <= IDX_W'(NUM_REQ - 1);
      idx         <= '0;
      data_q      <= '0;
      timer       <= '0;
      pending_cfg <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      idx         <= idx_nxt;
      data_q      <= data_nxt;
      timer       <= timer_nxt;
      pending_cfg <= pending_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a small UART busy-flag model.
// Inputs change and outputs are sampled just after the falling clock edge.
module tb_uart_tx_scheduler;

  localparam int NUM_REQ = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [3:0]           cfg_baud_sel;
  logic [1:0]           cfg_frame_size;
  logic [1:0]           cfg_parity;
  logic                 cfg_stop_bit;
  logic                 cfg_apply;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   tx_done;
  logic                 tx_err;
  logic                 ctl_reg_we;
  logic [18:0]          ctl_reg_wdata;
  logic [18:0]          ctl_reg_wmask;
  logic [18:0]          ctl_reg_rdata;
  logic                 st_reg_re;
  logic [11:0]          st_reg_rmask;
  logic [11:0]          st_reg_rdata;

  int checks = 0;
  int errors = 0;

  // UART model: busy rises busy_delay edges after an active-set write, stays busy_len cycles.
  int   busy_delay = 3;
  int   busy_len   = 20;
  bit   busy_never = 1'b0;
  int   phase;
  int   cnt;
  logic busy_m;

  assign st_reg_rdata = {11'b0, busy_m};

  always #5 clk = ~clk;

  uart_tx_scheduler #(.NUM_REQ(NUM_REQ), .ST_BUSY_BIT(0), .START_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .cfg_baud_sel(cfg_baud_sel), .cfg_frame_size(cfg_frame_size),
    .cfg_parity(cfg_parity), .cfg_stop_bit(cfg_stop_bit), .cfg_apply(cfg_apply),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_done(tx_done), .tx_err(tx_err),
    .ctl_reg_we(ctl_reg_we), .ctl_reg_wdata(ctl_reg_wdata), .ctl_reg_wmask(ctl_reg_wmask),
    .ctl_reg_rdata(ctl_reg_rdata),
    .st_reg_re(st_reg_re), .st_reg_rmask(st_reg_rmask), .st_reg_rdata(st_reg_rdata)
  );

  always @(posedge clk) begin
    if (rst) begin
      phase  <= 0;
      cnt    <= 0;
      busy_m <= 1'b0;
    end else if (ctl_reg_we && ctl_reg_wmask[0] && ctl_reg_wdata[0]) begin
      busy_m <= 1'b0;
      cnt    <= busy_delay;
      phase  <= busy_never ? 0 : 1;
    end else if (phase == 1) begin
      if (cnt <= 1) begin
        busy_m <= 1'b1;
        cnt    <= busy_len;
        phase  <= 2;
      end else cnt <= cnt - 1;
    end else if (phase == 2) begin
      if (cnt <= 1) begin
        busy_m <= 1'b0;
        phase  <= 0;
      end else cnt <= cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_we"},    32'(ctl_reg_we), 0);
    check({tag, "_wdata"}, 32'(ctl_reg_wdata), 0);
    check({tag, "_wmask"}, 32'(ctl_reg_wmask), 0);
    check({tag, "_re"},    32'(st_reg_re), 0);
    check({tag, "_rmask"}, 32'(st_reg_rmask), 0);
    check({tag, "_ready"}, 32'(req_ready), 0);
    check({tag, "_done"},  32'(tx_done), 0);
    check({tag, "_err"},   32'(tx_err), 0);
  endtask

  // Pulse reset for one edge, check the quiet port, release and check the CFG write.
  task automatic do_reset(input string tag, input logic [31:0] cfg_wdata);
    rst = 1'b1;
    @(negedge clk); #1;
    check_quiet({tag, "_rst"});
    @(negedge clk);
    rst = 1'b0;
    #1;
    check({tag, "_cfg_we"},    32'(ctl_reg_we), 1);
    check({tag, "_cfg_wdata"}, 32'(ctl_reg_wdata), cfg_wdata);
    check({tag, "_cfg_wmask"}, 32'(ctl_reg_wmask), 32'h003FE);
  endtask

  task automatic wait_done(input string tag, input int bound);
    int n;
    n = 0;
    while (tx_done == '0 && n < bound) begin
      @(negedge clk); #1;
      n++;
    end
    check({tag, "_in_time"}, 32'(tx_done != '0), 1);
  endtask

  logic [1:0] exp_rr [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [7:0] exp_by [4] = '{8'h11, 8'h22, 8'h11, 8'h22};

  initial begin
    int n;
    bit saw_done;
    rst            = 1'b1;
    cfg_baud_sel   = 4'd7;
    cfg_frame_size = 2'd3;
    cfg_parity     = 2'd0;
    cfg_stop_bit   = 1'b0;
    cfg_apply      = 1'b0;
    req_valid      = '0;
    req_data       = '0;
    ctl_reg_rdata  = '0;

    // Reset and the automatic configuration write.
    repeat (3) @(negedge clk);
    #1;
    check_quiet("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("cfg_we",    32'(ctl_reg_we), 1);
    check("cfg_wdata", 32'(ctl_reg_wdata), 32'h001C6);
    check("cfg_wmask", 32'(ctl_reg_wmask), 32'h003FE);
    @(negedge clk); #1;
    check("arb_we", 32'(ctl_reg_we), 0);
    check("arb_re", 32'(st_reg_re), 0);

    // Single byte from requester 0.
    req_data  = {8'h00, 8'hA5};
    req_valid = 2'b01;
    #1;
    check("a5_ready", 32'(req_ready), 32'b01);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("a5_load_wdata", 32'(ctl_reg_wdata), 32'h52DC7);
    check("a5_load_byte",  32'(ctl_reg_wdata[18:11]), 32'hA5);
    check("a5_load_wmask", 32'(ctl_reg_wmask), 32'h7FC01);
    n = 0;
    while (n < 100) begin
      @(negedge clk); #1;
      n++;
      if (n == 1) begin
        check("a5_poll_re",    32'(st_reg_re), 1);
        check("a5_poll_rmask", 32'(st_reg_rmask), 1);
      end
      if (tx_done != '0) break;
    end
    check("a5_done_latency", n, 24);
    check("a5_done_vec", 32'(tx_done), 32'b01);
    @(negedge clk); #1;
    check("a5_clr_we",    32'(ctl_reg_we), 1);
    check("a5_clr_wmask", 32'(ctl_reg_wmask), 32'h00001);
    check("a5_clr_wdata", 32'(ctl_reg_wdata), 32'h52DC6);
    @(negedge clk); #1;
    check("a5_post_we", 32'(ctl_reg_we), 0);

    // Round robin with both requesters held valid.
    do_reset("rr", 32'h001C6);
    busy_delay = 1;
    busy_len   = 2;
    req_data   = {8'h22, 8'h11};
    req_valid  = 2'b11;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      do begin
        @(negedge clk); #1;
        n++;
      end while (req_ready == '0 && n < 50);
      check("rr_onehot", 32'($onehot(req_ready)), 1);
      check("rr_order",  32'(req_ready), 32'(exp_rr[g]));
      @(negedge clk); #1;
      check("rr_byte", 32'(ctl_reg_wdata[18:11]), 32'(exp_by[g]));
    end
    req_valid = '0;
    wait_done("rr_last", 50);
    @(negedge clk);
    @(negedge clk); #1;

    // Busy never rises: start timeout.
    busy_never = 1'b1;
    req_data   = {8'h22, 8'h5A};
    req_valid  = 2'b01;
    #1;
    check("to_ready", 32'(req_ready), 32'b01);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("to_load_wmask", 32'(ctl_reg_wmask), 32'h7FC01);
    n = 0;
    saw_done = 1'b0;
    while (n < 200) begin
      @(negedge clk); #1;
      n++;
      if (tx_done != '0) saw_done = 1'b1;
      if (tx_err) break;
    end
    check("to_latency", n, 64);
    check("to_no_done", 32'(saw_done), 0);
    @(negedge clk); #1;
    check("to_clr_we",    32'(ctl_reg_we), 1);
    check("to_clr_wmask", 32'(ctl_reg_wmask), 32'h00001);
    check("to_err_pulse", 32'(tx_err), 0);
    @(negedge clk); #1;
    check("to_arb_we", 32'(ctl_reg_we), 0);
    busy_never = 1'b0;
    busy_delay = 3;
    busy_len   = 20;

    // cfg_apply during WAIT_DONE (pulsed twice) while requester 1 waits.
    req_valid = 2'b01;
    #1;
    check("ca_ready0", 32'(req_ready), 32'b01);
    @(negedge clk);
    req_valid = 2'b10;
    repeat (8) @(negedge clk);
    #1;
    check("ca_wait_done_re", 32'(st_reg_re), 1);
    cfg_baud_sel = 4'd3;
    cfg_apply    = 1'b1;
    @(negedge clk);
    cfg_apply = 1'b0;
    @(negedge clk);
    cfg_apply = 1'b1;
    @(negedge clk);
    cfg_apply = 1'b0;
    #1;
    wait_done("ca_byte0", 50);
    check("ca_done_vec", 32'(tx_done), 32'b01);
    @(negedge clk); #1;
    check("ca_clr_wmask", 32'(ctl_reg_wmask), 32'h00001);
    check("ca_clr_bit0",  32'(ctl_reg_wdata[0]), 0);
    @(negedge clk); #1;
    check("ca_arb_no_grant", 32'(req_ready), 0);
    check("ca_arb_we",       32'(ctl_reg_we), 0);
    @(negedge clk); #1;
    check("ca_cfg_we",    32'(ctl_reg_we), 1);
    check("ca_cfg_wmask", 32'(ctl_reg_wmask), 32'h003FE);
    check("ca_cfg_wdata", 32'(ctl_reg_wdata), 32'h000C6);
    check("ca_cfg_baud",  32'(ctl_reg_wdata[9:6]), 3);
    @(negedge clk); #1;
    check("ca_ready1", 32'(req_ready), 32'b10);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("ca_load1_wdata", 32'(ctl_reg_wdata), 32'h114C7);

    // Reset in the middle of WAIT_DONE aborts the byte silently.
    repeat (8) @(negedge clk);
    #1;
    check("mid_wait_done_re", 32'(st_reg_re), 1);
    do_reset("mid", 32'h000C6);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (tx_done != '0) saw_done = 1'b1;
    end
    check("mid_no_done", 32'(saw_done), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Multi-requester transmit scheduler sitting in the user tile in front of the UART IP control/status register port.
- Arbitrates byte-send requests round-robin and programs the UART configuration fields.
- Sequences each transmission through the control register: load data, set active, poll status busy, clear active.
- Reports per-requester completion and a start-timeout error.

Parameters:
NUM_REQ, 2, number of requesters (1..8)
ST_BUSY_BIT, 0, index in st_reg_rdata that reads 1 while a frame is shifting out
START_TIMEOUT, 64, cycles allowed in WAIT_START for busy to rise before error

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cfg_baud_sel  in  4  baud select, written to ctl bits [9:6]
cfg_frame_size  in  2  frame size, ctl bits [2:1]
cfg_parity  in  2  parity config, ctl bits [4:3]
cfg_stop_bit  in  1  stop bit config, ctl bit [5]
cfg_apply  in  1  pulse: rewrite config fields
req_valid  in  NUM_REQ  per-requester send request
req_data  in  8*NUM_REQ  byte i at [8i+7:8i]
req_ready  out  NUM_REQ  one-hot pulse: request i accepted this cycle
tx_done  out  NUM_REQ  one-hot pulse: byte of requester i finished
tx_err  out  1  pulse: busy never rose within START_TIMEOUT
ctl_reg_we  out  1  control register write strobe
ctl_reg_wdata  out  19  control write data
ctl_reg_wmask  out  19  control write bit mask
ctl_reg_rdata  in  19  control readback (unused, reserved)
st_reg_re  out  1  status read strobe
st_reg_rmask  out  12  status read mask
st_reg_rdata  in  12  status read data, valid in the same cycle as st_reg_re

Behaviour:
- Control register layout: [0] active, [2:1] frame_size, [4:3] parity, [5] stop_bit, [9:6] baud_sel, [10] tnsm_en, [18:11] data.
- Reset state: all outputs 0, FSM=CFG, RR pointer=NUM_REQ-1 (so requester 0 wins first), pending_cfg=0.
- Config write happens automatically after reset.
- CFG (1 cycle): we=1, wdata={8'h0,1'b0,baud,stop,parity,frame,1'b0}, wmask=19'h003FE; then goes to ARB.
- ARB:
  - If pending_cfg=1, go to CFG and clear pending_cfg.
  - Otherwise, if any req_valid, grant the first set index searching from ptr+1 with wrap.
  - On grant: req_ready[i]=1 that cycle, latch byte and index, ptr<=i, go to LOAD.
  - No valid request: stay in ARB.
- LOAD (1 cycle): we=1, wdata={byte,1'b1,cfg fields,1'b1}, wmask=19'h7FC01 (data, tnsm_en, active only); go to WAIT_START, timer=0.
- WAIT_START:
  - st_reg_re=1 and st_reg_rmask=1<<ST_BUSY_BIT every cycle.
  - busy=1: go to WAIT_DONE.
  - Otherwise timer++; at timer==START_TIMEOUT-1 with busy still 0: tx_err=1 for 1 cycle, go to CLEAR with no tx_done.
- WAIT_DONE: poll as above; busy=0 gives tx_done[idx]=1 for 1 cycle and goes to CLEAR.
- CLEAR (1 cycle): we=1, wdata bit0=0 (other bits as LOAD), wmask=19'h00001; go to ARB.
- ctl_reg_we is 1 only in CFG/LOAD/CLEAR; wmask=0 whenever we=0.
- cfg_apply:
  - In ARB: CFG is entered on the next cycle.
  - Any other state: sets pending_cfg, honoured at the next ARB.
  - Fields are sampled when the CFG write is issued, not when the pulse arrives.
  - A second pulse before service is merged.
- Minimum request-to-request spacing: 5 cycles (ARB, LOAD, ≥1 WAIT_START, ≥1 WAIT_DONE, CLEAR).
- req_valid dropped before grant: ignored. req_data is only sampled on the grant cycle.
- rst=1 in any state (including mid-frame): return to reset state next edge. Active is not explicitly cleared; the CFG write after reset leaves bit0 untouched, and the UART is reset by the same rst.
- NUM_REQ=1: arbitration degenerates to always granting index 0.

Test Plan:
- Reset release, cfg baud=7 frame=3 parity=0 stop=0 -> first cycle after reset: we=1, wdata=19'h001C6, wmask=19'h003FE; FSM in ARB next cycle.
- Req0 valid, data 8'hA5; model busy high 3 cycles after LOAD for 20 cycles:
  - LOAD: wdata[18:11]=8'hA5, bits 10 and 0 =1, wmask=19'h7FC01.
  - tx_done[0] pulses on the first busy-low cycle, then CLEAR with wmask=19'h00001.
- Req0 and req1 valid continuously with bytes 11/22 -> grant order 0,1,0,1; exactly one req_ready bit per grant.
- Busy held 0 forever -> tx_err pulses exactly START_TIMEOUT=64 cycles after entering WAIT_START; no tx_done; CLEAR then ARB.
- cfg_apply with baud=3 pulsed during WAIT_DONE while req1 pending -> CFG write (baud bits=4'h3) occurs before req1's LOAD.
- rst asserted mid-WAIT_DONE -> next cycle all outputs 0; CFG write follows release; no tx_done for the aborted byte.
